fft_addr_seq: RTL and testbench
===============================

// Module: fft_addr_seq
// PURPOSE
// - Self-sequencing address generator for the 4-bank radix-4 FFT buffer.
// - Owns its own phase/stage/cycle counter; caller only issues start and stall.
// - Per cycle it drives one address per bank (A..D) for three phases:
//   LOAD (input write), NSTG butterfly stages, UNLOAD (result read).
// - Sits between the FFT top control and the four bank SRAMs; the butterfly datapath consumes slot/stage.
// PARAMETERS
// - ADDR_W   8   bank address width; even, >=4; bank depth 2^ADDR_W; NSTG = ADDR_W/2 stages
// - CNT_W    ADDR_W+2   internal counter width (derived, do not override)
// PORTS
// - clk        in   1       clock, rising edge
// - rst_n      in   1       asynchronous active-low reset
// - start      in   1       start request; accepted only in IDLE
// - skip_load  in   1       sampled with start; 1 = skip LOAD, go straight to stage 0
// - stall      in   1       1 = hold counter and all outputs this cycle
// - busy       out  1       1 from cycle after start accepted until DONE cycle inclusive
// - addr_vld   out  1       A..D_addr valid this cycle (busy & ~stall, registered)
// - phase      out  2       0 IDLE, 1 LOAD, 2 STAGE, 3 UNLOAD
// - stage      out  clog2(NSTG)  current stage index s (0 outside STAGE)
// - slot       out  2       sub-cycle within a 4-cycle group (LOAD: bank select)
// - A_addr..D_addr  out  ADDR_W  per-bank addresses
// - done       out  1       single-cycle pulse after last UNLOAD address
// BEHAVIOUR
// - Reset: phase=IDLE, counter=0, busy=0, addr_vld=0, done=0, stage=0, slot=0, all addrs=0.
// - Outputs are registered; first address appears the cycle after start is accepted.
// - IDLE: start=1 -> LOAD (skip_load=0) or STAGE s=0 (skip_load=1); counter cleared.
// - LOAD: 2^(ADDR_W+2) cycles; all addrs = cnt[CNT_W-1:2], slot = cnt[1:0].
// - STAGE s: 2^ADDR_W cycles; group g = cnt[ADDR_W-1:2], slot = cnt[1:0];
//   lane k (A=0..D=3) addr = g with 2-bit digit k inserted at bits
//   [ADDR_W-1-2s : ADDR_W-2-2s]; upper bits of g stay above, lower bits below.
// - After last cycle of stage NSTG-1 -> UNLOAD; else s+1 with counter cleared.
// - UNLOAD: 2^ADDR_W cycles; all addrs = cnt[ADDR_W-1:0].
// - After last UNLOAD cycle: done=1 for one cycle, busy drops with it next cycle, -> IDLE.
// - stall=1: counter, phase, stage, addrs frozen; addr_vld=0; done deferred until unstalled.
// - start while busy: ignored. start and stall both high in IDLE: start accepted.
// - Counter wrap at phase end is a phase transition, never a silent wrap.
// - rst_n low mid-operation: immediate return to reset state; no done pulse.
// CONFIGURATION
// - FFT_ADDR_BITREV_EN defined: UNLOAD addrs = base-4 digit reversal of
//   cnt[ADDR_W-1:0] (2-bit digits reversed) for natural-order output.
// - Not defined: UNLOAD addrs linear, cnt[ADDR_W-1:0]; reordering done downstream.
// TESTING (ADDR_W=8, NSTG=4)
// - start, skip_load=0, no stall -> LOAD 1024, 4x256 STAGE, UNLOAD 256; done at cycle 2305 after start.
// - STAGE s=0, cnt=0x14 -> A=0x05 B=0x45 C=0x85 D=0xC5, slot=0.
// - STAGE s=2, cnt=0x14 -> A=0x11 B=0x15 C=0x19 D=0x1D; s=3 cnt=0x14 -> A=0x14..D=0x17.
// - stall high 10 cycles in STAGE 1 -> addrs frozen, addr_vld=0, done delayed by 10 cycles.
// - UNLOAD cnt=0x1B -> all addrs 0x1B (macro off) / 0xE4 (FFT_ADDR_BITREV_EN on).
// - rst_n low during STAGE 2 -> all outputs 0 asynchronously; next start restarts at LOAD cnt=0.

Source files
------------

// File: rtl/fft_addr_seq_if.sv
// Handshake and address bus between the FFT control, the address sequencer and the bank SRAMs.
// The master is the FFT top control; the slave is the address sequencer.
interface fft_addr_seq_if #(
  parameter int ADDR_W = 8
);
  localparam int NSTG  = ADDR_W / 2;
  localparam int STG_W = (NSTG > 1) ? $clog2(NSTG) : 1;

  logic              start;
  logic              skip_load;
  logic              stall;
  logic              busy;
  logic              addr_vld;
  logic              done;
  logic [1:0]        phase;
  logic [STG_W-1:0]  stage;
  logic [1:0]        slot;
  logic [ADDR_W-1:0] A_addr;
  logic [ADDR_W-1:0] B_addr;
  logic [ADDR_W-1:0] C_addr;
  logic [ADDR_W-1:0] D_addr;

  modport master (
    output start, skip_load, stall,
    input  busy, addr_vld, done, phase, stage, slot,
    input  A_addr, B_addr, C_addr, D_addr
  );

  modport slave (
    input  start, skip_load, stall,
    output busy, addr_vld, done, phase, stage, slot,
    output A_addr, B_addr, C_addr, D_addr
  );
endinterface

// File: rtl/fft_addr_seq.sv
// Self-sequencing 4-bank radix-4 FFT address generator: LOAD, NSTG butterfly stages, UNLOAD.
// Define FFT_ADDR_BITREV_EN to emit UNLOAD addresses in base-4 digit-reversed order.
module fft_addr_seq #(
  parameter int ADDR_W = 8
) (
  input logic           clk,
  input logic           rst_n,
  fft_addr_seq_if.slave bus
);
  localparam int CNT_W = ADDR_W + 2;
  localparam int NSTG  = ADDR_W / 2;
  localparam int STG_W = (NSTG > 1) ? $clog2(NSTG) : 1;

  localparam logic [CNT_W-1:0] LOAD_LAST  = '1;
  localparam logic [CNT_W-1:0] PHASE_LAST = {2'b00, {ADDR_W{1'b1}}};
  localparam logic [STG_W-1:0] STG_LAST   = STG_W'(NSTG - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STAGE,
    ST_UNLOAD,
    ST_DONE
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [STG_W-1:0]  stage, stage_d;
  logic              fresh, fresh_d;
  logic              vld, vld_d;
  logic              adv;
  logic [ADDR_W-1:0] addr_q [4];
  logic [ADDR_W-1:0] addr_d [4];

  // fresh marks a counter value that was loaded under stall and has not yet been shown valid,
  // so the first unstalled cycle re-presents it instead of skipping past it.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    stage_d = stage;
    fresh_d = fresh;
    adv     = ~bus.stall & ~fresh;
    if (!bus.stall) fresh_d = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = bus.skip_load ? ST_STAGE : ST_LOAD;
          cnt_d   = '0;
          stage_d = '0;
          fresh_d = bus.stall;
        end
      end
      ST_LOAD: begin
        if (adv) begin
          if (cnt == LOAD_LAST) begin
            state_d = ST_STAGE;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      ST_STAGE: begin
        if (adv) begin
          if (cnt == PHASE_LAST) begin
            cnt_d = '0;
            if (stage == STG_LAST) begin
              state_d = ST_UNLOAD;
              stage_d = '0;
            end else begin
              stage_d = stage + 1'b1;
            end
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      ST_UNLOAD: begin
        if (adv) begin
          if (cnt == PHASE_LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    vld_d = (state_d inside {ST_LOAD, ST_STAGE, ST_UNLOAD}) & ~bus.stall;
  end

  logic [ADDR_W-1:0] grp;
  logic [ADDR_W-1:0] lo_mask;
  logic [ADDR_W-1:0] rev;
  int                pos;

  // Stage s splits the group index at the digit position (ADDR_W-2-2s) and inserts the lane
  // number there, so the four lanes of one butterfly land in four different banks.
  always_comb begin
    grp     = {2'b00, cnt_d[ADDR_W-1:2]};
    pos     = ADDR_W - 2 - 2 * int'(stage_d);
    lo_mask = (ADDR_W'(1) << pos) - 1'b1;
    rev     = '0;
    for (int i = 0; i < NSTG; i++) begin
      rev[2*i +: 2] = cnt_d[ADDR_W-2-2*i +: 2];
    end
    for (int k = 0; k < 4; k++) begin
      case (state_d)
        ST_LOAD:  addr_d[k] = cnt_d[CNT_W-1:2];
        ST_STAGE: addr_d[k] = ((grp >> pos) << (pos + 2)) | (ADDR_W'(k) << pos) | (grp & lo_mask);
`ifdef FFT_ADDR_BITREV_EN
        ST_UNLOAD: addr_d[k] = rev;
`else
        ST_UNLOAD: addr_d[k] = cnt_d[ADDR_W-1:0];
`endif
        default:  addr_d[k] = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      stage <= '0;
      fresh <= 1'b0;
      vld   <= 1'b0;
      for (int k = 0; k < 4; k++) addr_q[k] <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      stage <= stage_d;
      fresh <= fresh_d;
      vld   <= vld_d;
      for (int k = 0; k < 4; k++) addr_q[k] <= addr_d[k];
    end
  end

  always_comb begin
    case (state)
      ST_LOAD:   bus.phase = 2'd1;
      ST_STAGE:  bus.phase = 2'd2;
      ST_UNLOAD: bus.phase = 2'd3;
      default:   bus.phase = 2'd0;
    endcase
  end

  assign bus.busy     = (state != ST_IDLE);
  assign bus.done     = (state == ST_DONE);
  assign bus.addr_vld = vld;
  assign bus.stage    = stage;
  assign bus.slot     = cnt[1:0];
  assign bus.A_addr   = addr_q[0];
  assign bus.B_addr   = addr_q[1];
  assign bus.C_addr   = addr_q[2];
  assign bus.D_addr   = addr_q[3];
endmodule

// File: tb/tb_fft_addr_seq.sv
// Scoreboard bench for fft_addr_seq (ADDR_W=8): full runs, skip_load, stalls, ignored start,
// start under stall and asynchronous reset mid-run.
module tb_fft_addr_seq;
  localparam int AW   = 8;
  localparam int NSTG = AW / 2;

  typedef struct {
    logic [1:0]    phase;
    logic [1:0]    stage;
    logic [1:0]    slot;
    logic [AW-1:0] addr [4];
    logic          vld;
    logic          busy;
    logic          done;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;
  int   ncyc = 0;
  exp_t sb[$];

  fft_addr_seq_if #(.ADDR_W(AW)) bus ();

  fft_addr_seq #(.ADDR_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int cyc, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", name, cyc, obs, exp);
    end
  endtask

  // Reference address model written with base-4 digit arithmetic rather than bit slicing.
  function automatic int modelAddr(input int ph, input int s, input int cnt, input int k);
    int place, g, r, c;
    case (ph)
      1: return cnt / 4;
      2: begin
        place = 1;
        for (int j = 0; j < NSTG - 1 - s; j++) place = place * 4;
        g = cnt / 4;
        return (g / place) * place * 4 + k * place + g % place;
      end
      3: begin
`ifdef FFT_ADDR_BITREV_EN
        r = 0;
        c = cnt;
        for (int j = 0; j < NSTG; j++) begin
          r = r * 4 + c % 4;
          c = c / 4;
        end
        return r;
`else
        return cnt;
`endif
      end
      default: return 0;
    endcase
  endfunction

  task automatic pushExp(input int ph, input int s, input int cnt, input bit vld, input bit busy, input bit done);
    exp_t e;
    e.phase = 2'(ph);
    e.stage = 2'(s);
    e.slot  = (ph == 0) ? 2'd0 : 2'(cnt % 4);
    for (int k = 0; k < 4; k++) e.addr[k] = AW'(modelAddr(ph, s, cnt, k));
    e.vld  = vld;
    e.busy = busy;
    e.done = done;
    e.cyc  = ncyc;
    ncyc++;
    sb.push_back(e);
  endtask

  task automatic applyStimulus(input bit st, input bit sk, input bit sl, input int ph, input int s, input int cnt, input bit vld);
    @(negedge clk);
    #1;
    bus.start     = st;
    bus.skip_load = sk;
    bus.stall     = sl;
    pushExp(ph, s, cnt, vld, ph != 0, 1'b0);
  endtask

  task automatic endRun();
    @(negedge clk);
    #1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    pushExp(0, 0, 0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    pushExp(0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkZero(input int tag);
    checkOutput("rst_busy",  tag, 16'(bus.busy), 16'd0);
    checkOutput("rst_vld",   tag, 16'(bus.addr_vld), 16'd0);
    checkOutput("rst_done",  tag, 16'(bus.done), 16'd0);
    checkOutput("rst_phase", tag, 16'(bus.phase), 16'd0);
    checkOutput("rst_stage", tag, 16'(bus.stage), 16'd0);
    checkOutput("rst_slot",  tag, 16'(bus.slot), 16'd0);
    checkOutput("rst_A",     tag, 16'(bus.A_addr), 16'd0);
    checkOutput("rst_B",     tag, 16'(bus.B_addr), 16'd0);
    checkOutput("rst_C",     tag, 16'(bus.C_addr), 16'd0);
    checkOutput("rst_D",     tag, 16'(bus.D_addr), 16'd0);
  endtask

  // One scoreboard entry is retired per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checkOutput("phase", e.cyc, 16'(bus.phase), 16'(e.phase));
      checkOutput("stage", e.cyc, 16'(bus.stage), 16'(e.stage));
      checkOutput("slot",  e.cyc, 16'(bus.slot), 16'(e.slot));
      checkOutput("A",     e.cyc, 16'(bus.A_addr), 16'(e.addr[0]));
      checkOutput("B",     e.cyc, 16'(bus.B_addr), 16'(e.addr[1]));
      checkOutput("C",     e.cyc, 16'(bus.C_addr), 16'(e.addr[2]));
      checkOutput("D",     e.cyc, 16'(bus.D_addr), 16'(e.addr[3]));
      checkOutput("vld",   e.cyc, 16'(bus.addr_vld), 16'(e.vld));
      checkOutput("busy",  e.cyc, 16'(bus.busy), 16'(e.busy));
      checkOutput("done",  e.cyc, 16'(bus.done), 16'(e.done));
    end
  end

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.skip_load = 1'b0;
    bus.stall     = 1'b0;
    #2;
    checkZero(-1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] run 1: full LOAD/STAGE/UNLOAD, no stall");
    applyStimulus(1, 0, 0, 1, 0, 0, 1);
    for (int i = 1; i < 1024; i++) applyStimulus(0, 0, 0, 1, 0, i, 1);
    for (int s = 0; s < NSTG; s++)
      for (int i = 0; i < 256; i++) applyStimulus(0, 0, 0, 2, s, i, 1);
    for (int i = 0; i < 256; i++) applyStimulus(0, 0, 0, 3, 0, i, 1);
    endRun();

    $display("[TB] run 2: skip_load, start while busy, stalls in STAGE 1 and at UNLOAD end");
    applyStimulus(1, 1, 0, 2, 0, 0, 1);
    for (int i = 1; i < 256; i++) applyStimulus(i == 7 || i == 8, 0, 0, 2, 0, i, 1);
    for (int i = 0; i < 256; i++) begin
      if (i == 100)
        for (int j = 0; j < 10; j++) applyStimulus(0, 0, 1, 2, 1, 99, 0);
      applyStimulus(0, 0, 0, 2, 1, i, 1);
    end
    for (int s = 2; s < NSTG; s++)
      for (int i = 0; i < 256; i++) applyStimulus(0, 0, 0, 2, s, i, 1);
    for (int i = 0; i < 256; i++) applyStimulus(0, 0, 0, 3, 0, i, 1);
    for (int j = 0; j < 3; j++) applyStimulus(0, 0, 1, 3, 0, 255, 0);
    endRun();

    $display("[TB] run 3: start under stall, then reset during STAGE 2");
    applyStimulus(1, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    for (int i = 1; i < 1024; i++) applyStimulus(0, 0, 0, 1, 0, i, 1);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++) applyStimulus(0, 0, 0, 2, s, i, 1);
    for (int i = 0; i <= 50; i++) applyStimulus(0, 0, 0, 2, 2, i, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkZero(-2);
    repeat (2) @(negedge clk);
    checkOutput("rst_hold_done", -3, 16'(bus.done), 16'd0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 1, 0, 0, 1);
    for (int i = 1; i < 20; i++) applyStimulus(0, 0, 0, 1, 0, i, 1);

    repeat (4) @(negedge clk);
    checkOutput("drain", -4, 16'(sb.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
